uart_rx: RTL

//  Receive side of the board UART link (8N1, LSB first, no flow control). Samples i_Rx_Serial at bit centres,

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions
// Purpose: FSM state encoding and frame constants shared by the UART receive
//          path and future transmit-side upgrades.
// Ports:   none (package).
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser, resets to line-idle (1)
// Purpose: bring an asynchronous input into the i_Clock domain.
// Ports:
//   i_Clock  in  1  sampling clock
//   i_Reset  in  1  asynchronous, active-high reset; both flops go to 1
//   i_Async  in  1  asynchronous input
//   o_Sync   out 1  synchronised copy of i_Async (two cycles of latency)
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);

  logic meta;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      meta   <= 1'b1;
      o_Sync <= 1'b1;
    end else begin
      meta   <= i_Async;
      o_Sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8 data bits, LSB first, optional parity
// Purpose: samples the serial line at bit centres, reassembles one byte per
//          frame, pulses o_Rx_DV with the byte and flags malformed frames.
// Configuration macro: UART_RX_PARITY_EN adds a parity bit (sense set by
//          PARITY_ODD) and the o_Parity_Err port; undefined gives plain 8N1.
// Ports:
//   i_Clock      in  1  system clock
//   i_Reset      in  1  asynchronous, active-high reset
//   i_Rx_Serial  in  1  asynchronous serial line, idles high
//   o_Rx_DV      out 1  one-cycle pulse: o_Rx_Byte holds a new good byte
//   o_Rx_Byte    out 8  last good byte, held until the next good frame
//   o_Rx_Active  out 1  high from start-bit acceptance until the frame ends
//   o_Frame_Err  out 1  one-cycle pulse: stop bit sampled low
//   o_Parity_Err out 1  one-cycle pulse: parity mismatch (parity build only)
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY_ODD   = 0
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Frame_Err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_Parity_Err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_rx: CLKS_PER_BIT must be 4..65535 and PARITY_ODD 0 or 1");
  end

  logic          rx_s;
  uart_state_t   state;
  logic [CW-1:0] clk_count;
  logic [2:0]    bit_index;
  logic [7:0]    rx_shift;
  // Set when a frame ends with the line still low (break or framing error):
  // IDLE must see the line return high before a falling edge counts again.
  logic          wait_high;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic          par_err_q;
`endif

  uart_rx_sync u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (i_Rx_Serial),
    .o_Sync  (rx_s)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state        <= IDLE;
      clk_count    <= '0;
      bit_index    <= '0;
      rx_shift     <= '0;
      wait_high    <= 1'b0;
      o_Rx_DV      <= 1'b0;
      o_Rx_Byte    <= 8'h00;
      o_Rx_Active  <= 1'b0;
      o_Frame_Err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= 1'b0;
      o_Parity_Err <= 1'b0;
`endif
    end else begin
      // Status pulses default low so every pulse lasts exactly one cycle.
      o_Rx_DV      <= 1'b0;
      o_Frame_Err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_Parity_Err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          clk_count <= '0;
          bit_index <= '0;
`ifdef UART_RX_PARITY_EN
          par_err_q <= 1'b0;
`endif
          if (wait_high) begin
            if (rx_s) wait_high <= 1'b0;
          end else if (!rx_s) begin
            state <= START;
          end
        end

        START: begin
          if (clk_count == HALF_M1) begin
            clk_count <= '0;
            if (!rx_s) begin
              o_Rx_Active <= 1'b1;
              state       <= DATA;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              state <= IDLE;
            end
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end

        DATA: begin
          if (clk_count == FULL_M1) begin
            clk_count           <= '0;
            rx_shift[bit_index] <= rx_s;
            if (bit_index == LAST_IDX) begin
              bit_index <= '0;
`ifdef UART_RX_PARITY_EN
              state     <= PARITY;
`else
              state     <= STOP;
`endif
            end else begin
              bit_index <= bit_index + 1'b1;
            end
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_count == FULL_M1) begin
            clk_count <= '0;
            // Expected parity bit makes the total count of ones even (or odd).
            par_err_q <= (rx_s != ((^rx_shift) ^ PAR_ODD));
            state     <= STOP;
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end
`endif

        STOP: begin
          if (clk_count == FULL_M1) begin
            clk_count   <= '0;
            o_Rx_Active <= 1'b0;
            state       <= CLEANUP;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (par_err_q) begin
                o_Parity_Err <= 1'b1;
              end else begin
                o_Rx_Byte <= rx_shift;
                o_Rx_DV   <= 1'b1;
              end
`else
              o_Rx_Byte <= rx_shift;
              o_Rx_DV   <= 1'b1;
`endif
            end else begin
              o_Frame_Err <= 1'b1;
            end
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end

        CLEANUP: begin
          wait_high <= !rx_s;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
